// File: rtl/params_pkg.sv
// rtl/params_pkg.sv - shared widths and the fetch queue entry type
package params_pkg;

  localparam int ADDR_W   = 32;
  localparam int INST_W   = 32;
  localparam int FQ_DEPTH = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] instr;
    logic              fault;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order fetch-to-decode buffer with hold back-pressure and flush
module fetch_queue #(
  parameter int DEPTH  = params_pkg::FQ_DEPTH,
  parameter int ADDR_W = params_pkg::ADDR_W,
  parameter int INST_W = params_pkg::INST_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [ADDR_W-1:0]          in_pc,
  input  logic [INST_W-1:0]          in_instr,
  input  logic                       in_fault,
  output logic                       hold,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [INST_W-1:0]          out_instr,
  output logic                       out_fault,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       err_ovf
);
  import params_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $fatal(1, "fetch_queue: DEPTH must be a power of two and at least 2");
  end

  // Entries are stored as the shared struct, so the widths must agree with it.
  if ((ADDR_W != params_pkg::ADDR_W) || (INST_W != params_pkg::INST_W)) begin : g_bad_width
    $fatal(1, "fetch_queue: ADDR_W/INST_W must match params_pkg");
  end

  fq_entry_t       mem [DEPTH];
  fq_entry_t       head;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            push;
  logic            pop;

  // hold comes from registered count only, keeping out_ready off the fetch stall path.
  assign hold      = (count == FULL_CNT);
  assign out_valid = (count != '0) && !flush;
  assign push      = in_valid && !hold && !flush;
  assign pop       = out_valid && out_ready;
  assign head      = mem[rd_ptr];

  always_comb begin
    out_pc    = '0;
    out_instr = '0;
    out_fault = 1'b0;
    if (out_valid) begin
      out_pc    = head.pc;
      out_instr = head.instr;
      out_fault = head.fault;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_ovf <= 1'b0;
    end else if (in_valid && hold && !flush) begin
      err_ovf <= 1'b1;
    end
  end

  // Storage is deliberately left out of reset and flush; occupancy alone gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{pc: in_pc, instr: in_instr, fault: in_fault};
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard bench for fetch_queue
module tb_fetch_queue;
  import params_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic [ADDR_W-1:0] in_pc = '0;
  logic [INST_W-1:0] in_instr = '0;
  logic              in_fault = 1'b0;
  logic              hold;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [ADDR_W-1:0] out_pc;
  logic [INST_W-1:0] out_instr;
  logic              out_fault;
  logic [CW-1:0]     count;
  logic              err_ovf;

  fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INST_W(INST_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_fault(in_fault),
    .hold(hold), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_fault(out_fault),
    .count(count), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  int        vectors = 0;
  int        miscompares = 0;
  fq_entry_t sb[$];
  logic      exp_ovf = 1'b0;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required $finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic iv, input logic [ADDR_W-1:0] pc, input logic [INST_W-1:0] ins,
                       input logic flt, input logic ordy, input logic fl);
    in_valid  = iv;
    in_pc     = pc;
    in_instr  = ins;
    in_fault  = flt;
    out_ready = ordy;
    flush     = fl;
    #1;
  endtask

  // Advances one edge and updates the scoreboard from the inputs as driven.
  task automatic tick();
    logic      m_full, m_push, m_pop, m_fl;
    fq_entry_t e;
    m_full = (sb.size() == DEPTH);
    m_fl   = flush;
    m_push = in_valid && !m_full && !flush;
    m_pop  = (sb.size() != 0) && out_ready && !flush;
    e      = '{pc: in_pc, instr: in_instr, fault: in_fault};
    if (in_valid && m_full && !flush) exp_ovf = 1'b1;
    @(posedge clk);
    #1;
    if (m_fl) sb.delete();
    else begin
      if (m_pop)  void'(sb.pop_front());
      if (m_push) sb.push_back(e);
    end
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if (count !== '0 || out_valid !== 1'b0 || hold !== 1'b0 || err_ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL por_state: got count=%0d ov=%b hold=%b err=%b, required 0 0 0 0", count, out_valid, hold, err_ovf);
    end
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ADDR_W'(32'h200 + 4*i), INST_W'(32'hA0 + i), 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (count !== CW'(3)) begin
      miscompares++;
      $display("FAIL reset_prefill: got count=%0d, required 3", count);
    end
    rst = 1'b1;
    #2;
    vectors++;
    if (count !== '0 || out_valid !== 1'b0 || hold !== 1'b0 || err_ovf !== 1'b0 || out_pc !== '0) begin
      miscompares++;
      $display("FAIL reset_async: got count=%0d ov=%b hold=%b err=%b pc=%h, required all 0", count, out_valid, hold, err_ovf, out_pc);
    end
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    sb.delete();
    exp_ovf = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || count !== '0) begin
      miscompares++;
      $display("FAIL reset_release: got ov=%b count=%0d, required 0 0", out_valid, count);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, ADDR_W'(4*i), INST_W'(32'h11 * (i + 1)), 1'b0, 1'b0, 1'b0);
      tick();
      vectors++;
      if (count !== CW'(sb.size())) begin
        miscompares++;
        $display("FAIL fill_count: got %0d, required %0d", count, sb.size());
      end
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (hold !== 1'b1 || count !== CW'(4)) begin
      miscompares++;
      $display("FAIL fill_full: got hold=%b count=%0d, required 1 4", hold, count);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
      vectors++;
      if (out_valid !== 1'b1 || out_pc !== sb[0].pc || out_instr !== sb[0].instr
          || out_pc !== ADDR_W'(4*i) || out_instr !== INST_W'(32'h11 * (i + 1))) begin
        miscompares++;
        $display("FAIL drain_head: got ov=%b pc=%h instr=%h, required 1 %h %h", out_valid, out_pc, out_instr, sb[0].pc, sb[0].instr);
      end
      tick();
      if (i == 0) begin
        vectors++;
        if (hold !== 1'b0) begin
          miscompares++;
          $display("FAIL hold_drop: got %b, required 0", hold);
        end
      end
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (out_valid !== 1'b0 || count !== '0 || out_pc !== '0 || out_instr !== '0) begin
      miscompares++;
      $display("FAIL drained: got ov=%b count=%0d pc=%h instr=%h, required 0 0 0 0", out_valid, count, out_pc, out_instr);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, ADDR_W'(32'h100 + 4*i), INST_W'(32'hB0 + i), 1'b0, 1'b0, 1'b0);
      tick();
    end
    vectors++;
    if (err_ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_early: got %b, required 0", err_ovf);
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, ADDR_W'(32'h10), INST_W'(32'hDEAD), 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (err_ovf !== exp_ovf || err_ovf !== 1'b1 || count !== CW'(4)) begin
      miscompares++;
      $display("FAIL ovf_set: got err=%b count=%0d, required 1 4", err_ovf, count);
    end
    while (sb.size() != 0) begin
      drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
      vectors++;
      if (out_valid !== 1'b1 || out_pc !== sb[0].pc || out_pc === ADDR_W'(32'h10)) begin
        miscompares++;
        $display("FAIL ovf_drain: got ov=%b pc=%h, required 1 %h", out_valid, out_pc, sb[0].pc);
      end
      tick();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (err_ovf !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_sticky: got err=%b ov=%b, required 1 0", err_ovf, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, ADDR_W'(32'h300 + 4*i), INST_W'(32'hC0 + i), 1'b0, 1'b0, 1'b0);
      tick();
    end
    for (int i = 2; i < 10; i++) begin
      drive(1'b1, ADDR_W'(32'h300 + 4*i), INST_W'(32'hC0 + i), i[0], 1'b1, 1'b0);
      vectors++;
      if (out_valid !== 1'b1 || out_pc !== sb[0].pc || out_instr !== sb[0].instr || out_fault !== sb[0].fault) begin
        miscompares++;
        $display("FAIL b2b_head: got pc=%h instr=%h f=%b, required %h %h %b", out_pc, out_instr, out_fault, sb[0].pc, sb[0].instr, sb[0].fault);
      end
      tick();
      vectors++;
      if (count !== CW'(2)) begin
        miscompares++;
        $display("FAIL b2b_count: got %0d, required 2", count);
      end
    end
    while (sb.size() != 0) begin
      drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
      vectors++;
      if (out_pc !== sb[0].pc || out_fault !== sb[0].fault) begin
        miscompares++;
        $display("FAIL b2b_drain: got pc=%h f=%b, required %h %b", out_pc, out_fault, sb[0].pc, sb[0].fault);
      end
      tick();
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ADDR_W'(32'h400 + 4*i), INST_W'(32'hE0 + i), 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, ADDR_W'(32'h99), INST_W'(32'h99), 1'b0, 1'b1, 1'b1);
    vectors++;
    if (out_valid !== 1'b0 || out_pc !== '0) begin
      miscompares++;
      $display("FAIL flush_ov: got ov=%b pc=%h, required 0 0", out_valid, out_pc);
    end
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (count !== '0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_count: got count=%0d ov=%b, required 0 0", count, out_valid);
    end
    drive(1'b1, ADDR_W'(32'h40), INST_W'(32'h4040), 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (out_valid !== 1'b1 || out_pc !== sb[0].pc || out_pc !== ADDR_W'(32'h40)) begin
      miscompares++;
      $display("FAIL flush_next: got ov=%b pc=%h, required 1 00000040", out_valid, out_pc);
    end
    tick();
  endtask

  task automatic test_fault_bypass();
    drive(1'b1, ADDR_W'(32'h20), INST_W'(32'h2020), 1'b1, 1'b1, 1'b0);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bypass_ov: got %b, required 0", out_valid);
    end
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (out_valid !== 1'b1 || out_pc !== sb[0].pc || out_fault !== sb[0].fault || out_fault !== 1'b1) begin
      miscompares++;
      $display("FAIL fault_head: got ov=%b pc=%h f=%b, required 1 00000020 1", out_valid, out_pc, out_fault);
    end
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (out_valid !== 1'b0 || out_fault !== 1'b0 || count !== CW'(sb.size())) begin
      miscompares++;
      $display("FAIL fault_empty: got ov=%b f=%b count=%0d, required 0 0 0", out_valid, out_fault, count);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    rst = 1'b1;
    #2;
    @(posedge clk); #1 rst = 1'b0;
    sb.delete();
    exp_ovf = 1'b0;
    test_back_to_back();
    test_flush();
    test_fault_bypass();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue between the fetch stage and decode. It buffers up to DEPTH fetched {pc, instr, fault} entries from fetch and presents them in order to decode over a valid/ready handshake. It applies back-pressure to fetch through `hold` when full, and discards all contents on a pipeline `flush`.

## Interface
Parameters:
- DEPTH, 4, number of entries; must be a power of two and at least 2 (elaboration-time check, `$fatal` otherwise).
- ADDR_W, params_pkg::ADDR_W, PC width.
- INST_W, params_pkg::INST_W, instruction width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous squash of all entries.
- in_valid  in  1  fetch presents a latched instruction.
- in_pc  in  ADDR_W  PC of the presented instruction.
- in_instr  in  INST_W  presented instruction.
- in_fault  in  1  fetch address missed ROM (fetch `hit` = 0).
- hold  out  1  queue full; fetch must stall.
- out_valid  out  1  head entry available to decode.
- out_ready  in  1  decode accepts the head entry.
- out_pc  out  ADDR_W  head PC.
- out_instr  out  INST_W  head instruction.
- out_fault  out  1  head fault flag.
- count  out  $clog2(DEPTH+1)  current occupancy.
- err_ovf  out  1  sticky: a push was attempted while full.

## Operation
- push = in_valid & ~hold & ~flush.
- pop = out_valid & out_ready.
- Storage: DEPTH-entry array of fq_entry_t. Write pointer and read pointer are $clog2(DEPTH) bits and wrap naturally modulo DEPTH.
- count update per edge: +1 on push only, −1 on pop only, unchanged on both or neither.
- hold = (count == DEPTH), decoded from registered state only. There is no combinational path from out_ready to hold.
- out_valid = (count != 0) & ~flush. Decode can never consume an entry in a flush cycle.
- When out_valid = 0, out_pc, out_instr and out_fault are driven to 0. Otherwise they show the entry at the read pointer.
- Flush: at the edge, count, write pointer and read pointer go to 0. Any in_valid in that cycle is dropped. Storage contents are not cleared.
- Overflow: in_valid & hold & ~flush sets err_ovf. The data is dropped and the queue is unchanged. err_ovf clears only on rst.
- Empty with in_valid and out_ready in the same cycle: push only, no bypass. The entry becomes visible next cycle.
- Full with out_ready: pop only (push is blocked by hold). count becomes DEPTH−1 and hold drops next cycle.
- Fault entries are queued like any other entry. The fault is only reported at the head; decode decides what to do with it.

## Timing
- Reset (async assert, sync deassert use): count=0, pointers=0, hold=0, out_valid=0, out_pc/out_instr/out_fault=0, err_ovf=0.
- Reset mid-operation: all entries lost immediately. Outputs take reset values without waiting for clk.
- Push-to-out_valid latency: 1 cycle. An entry pushed at edge N is visible after edge N.
- Pop: the head advances at the edge where out_valid & out_ready. The next entry is visible immediately after that edge.
- Throughput: 1 push and 1 pop per cycle sustained when 0 < count < DEPTH.
- hold reflects occupancy after each edge. Fetch samples it in the same cycle to gate pc_we.
- flush takes priority over push and pop in the same cycle.

## Structure
- params_pkg: add `typedef struct packed {logic [ADDR_W-1:0] pc; logic [INST_W-1:0] instr; logic fault;} fq_entry_t;` and `FQ_DEPTH = 4`. ADDR_W and INST_W already live there.
- Single module with no sub-module. The pointer/count logic is small, and a generic FIFO would obscure the flush and zeroing rules.

## Test plan
- Reset: assert rst for 2 cycles mid-stream with 3 entries queued -> count=0, out_valid=0, hold=0, err_ovf=0 asynchronously. out_pc=0.
- Fill/drain: push pc 0x0,0x4,0x8,0xC with instr 0x11..0x44, out_ready=0 -> hold=1 and count=4 after the 4th edge. Then out_ready=1 -> outputs 0x0/0x11 through 0xC/0x44 in order and hold drops after the first pop.
- Overflow: full queue, in_valid=1 with pc 0x10 -> err_ovf=1 and stays 1. Entry 0x10 is never output. count stays 4.
- Simultaneous push/pop: count=2, push and pop each cycle for 8 cycles -> count stays 2, order preserved, pointers wrap past DEPTH with no loss.
- Flush: count=3, flush=1 with in_valid=1 and out_ready=1 -> out_valid=0 in the flush cycle and count=0 next cycle. The next push (pc 0x40) is the next output.
- Fault and empty bypass: empty queue, push pc 0x20 with in_fault=1 and out_ready=1 -> out_valid=0 that cycle. Next cycle out_valid=1, out_pc=0x20, out_fault=1.
